// File: rtl/id_scoreboard.sv
// ID-stage countdown scoreboard: per-register latency counters drive RAW/WAW stall.
// Optional statistics counters are enabled with macro ID_SCOREBOARD_STATS_EN.
module id_scoreboard #(
    parameter int NREG      = 32,
    parameter int MAX_LAT   = 7,
    parameter int FWD_SLACK = 1,
    parameter int BR_SLACK  = 0,
    localparam int AW = $clog2(NREG),
    localparam int LW = $clog2(MAX_LAT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic            id_rs_used,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rt_used,
    input  logic            id_is_branch,
    input  logic [AW-1:0]   id_dst,
    input  logic            id_dst_we,
    input  logic [LW-1:0]   id_lat,
    input  logic            flush,
    output logic            stall,
    output logic            issue,
    output logic [NREG-1:0] busy_vec
`ifdef ID_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [15:0]     raw_cnt,
    output logic [15:0]     waw_cnt
`endif
);

    logic [LW-1:0] cnt_r [NREG];
    logic [LW-1:0] lat_c_s;
    logic [LW-1:0] slack_s;
    logic          raw_rs_s;
    logic          raw_rt_s;
    logic          waw_s;
    logic          load_s;

    // Latency clamp, slack select and hazard detection for the ID-stage instruction
    always_comb begin
        lat_c_s  = (id_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : id_lat;
        slack_s  = id_is_branch ? LW'(BR_SLACK) : LW'(FWD_SLACK);
        raw_rs_s = id_rs_used & (id_rs != {AW{1'b0}}) & (cnt_r[id_rs] > slack_s);
        raw_rt_s = id_rt_used & (id_rt != {AW{1'b0}}) & (cnt_r[id_rt] > slack_s);
        // A pending write landing later than ours would overwrite the younger result.
        waw_s    = id_dst_we & (id_dst != {AW{1'b0}}) & (cnt_r[id_dst] > lat_c_s);
        stall    = id_valid & (raw_rs_s | raw_rt_s | waw_s);
        issue    = id_valid & ~stall;
        load_s   = issue & id_dst_we & (id_dst != {AW{1'b0}});
    end

    // Counter update: flush clears, otherwise count down and load the issuing destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= {LW{1'b0}};
            end
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= {LW{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (load_s && (id_dst == AW'(r))) begin
                    cnt_r[r] <= lat_c_s;
                end else if (cnt_r[r] != {LW{1'b0}}) begin
                    cnt_r[r] <= cnt_r[r] - {{(LW-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r[r] <= cnt_r[r];
                end
            end
        end
    end

    // Busy view of every counter
    always_comb begin
        busy_vec = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt_r[r] != {LW{1'b0}});
        end
    end

`ifdef ID_SCOREBOARD_STATS_EN
    logic raw_any_s;
    assign raw_any_s = raw_rs_s | raw_rt_s;

    // Saturating stall statistics, cleared by reset and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            raw_cnt   <= 16'd0;
            waw_cnt   <= 16'd0;
        end else if (flush) begin
            stall_cnt <= 32'd0;
            raw_cnt   <= 16'd0;
            waw_cnt   <= 16'd0;
        end else begin
            if (stall && (stall_cnt != {32{1'b1}})) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (stall && raw_any_s && (raw_cnt != {16{1'b1}})) begin
                raw_cnt <= raw_cnt + 16'd1;
            end else begin
                raw_cnt <= raw_cnt;
            end
            if (stall && waw_s && !raw_any_s && (waw_cnt != {16{1'b1}})) begin
                waw_cnt <= waw_cnt + 16'd1;
            end else begin
                waw_cnt <= waw_cnt;
            end
        end
    end
`endif

endmodule
